// File: rtl/mult8x8_seq_if.sv
// mult8x8_seq_if: request/result bundle for the sequential 8x8 multiplier.
// The master drives the operands and start level; the slave (the multiplier)
// returns the product, the done flag and the seven-segment state code.
interface mult8x8_seq_if;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [15:0] product8x8_out;
  logic        done_flag;
  logic [2:0]  seg_state;

  modport master (
    output start,
    output dataa,
    output datab,
    input  product8x8_out,
    input  done_flag,
    input  seg_state
  );

  modport slave (
    input  start,
    input  dataa,
    input  datab,
    output product8x8_out,
    output done_flag,
    output seg_state
  );
endinterface

// File: rtl/mult8x8_seq.sv
// mult8x8_seq: sequential 8x8 unsigned multiplier using one 4x4 multiplier.
// Four nibble partial products are shifted and accumulated over four cycles.
// The state register is encoded with the seven-segment display codes, so
// seg_state is the state register itself and cannot glitch.
// Optional build macro: MULT_HOLD_EN -- when defined, the product output is a
// separate register that keeps the previous result until the next one is ready;
// when undefined, the product output is the running accumulator.
module mult8x8_seq (
  input  logic          clk,
  input  logic          reset_a,
  mult8x8_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    CYC0 = 3'd0,
    CYC1 = 3'd1,
    CYC2 = 3'd2,
    CYC3 = 3'd3,
    DONE = 3'd4,
    IDLE = 3'd5
  } state_t;

  state_t      r_state;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [15:0] r_acc;
  logic        r_done;

  logic [3:0]  w_nibA;
  logic [3:0]  w_nibB;
  logic [7:0]  w_pp;
  logic [15:0] w_ppShifted;
  logic [15:0] w_accNext;

  // Select the operand nibbles and shift amount for the partial product of the current cycle
  always_comb begin
    w_nibA      = r_a[3:0];
    w_nibB      = r_b[3:0];
    w_pp        = 8'd0;
    w_ppShifted = 16'd0;
    case (r_state)
      CYC0: begin w_nibA = r_a[3:0]; w_nibB = r_b[3:0]; end
      CYC1: begin w_nibA = r_a[7:4]; w_nibB = r_b[3:0]; end
      CYC2: begin w_nibA = r_a[3:0]; w_nibB = r_b[7:4]; end
      CYC3: begin w_nibA = r_a[7:4]; w_nibB = r_b[7:4]; end
      default: begin w_nibA = 4'd0; w_nibB = 4'd0; end
    endcase
    w_pp = {4'd0, w_nibA} * {4'd0, w_nibB};
    case (r_state)
      CYC0:       w_ppShifted = {8'd0, w_pp};
      CYC1, CYC2: w_ppShifted = {4'd0, w_pp, 4'd0};
      CYC3:       w_ppShifted = {w_pp, 8'd0};
      default:    w_ppShifted = 16'd0;
    endcase
  end

  // 255*255 fits in 16 bits, so the carry-out is simply dropped
  assign w_accNext = r_acc + w_ppShifted;

  // Control FSM with operand capture, accumulation and a registered done flag
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      r_state <= IDLE;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_acc   <= 16'd0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_a     <= bus.dataa;
            r_b     <= bus.datab;
            r_acc   <= 16'd0;
            r_state <= CYC0;
            r_done  <= 1'b0;
          end
        end
        CYC0: begin
          r_acc   <= w_accNext;
          r_state <= CYC1;
        end
        CYC1: begin
          r_acc   <= w_accNext;
          r_state <= CYC2;
        end
        CYC2: begin
          r_acc   <= w_accNext;
          r_state <= CYC3;
        end
        CYC3: begin
          r_acc   <= w_accNext;
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MULT_HOLD_EN
  logic [15:0] r_product;

  // Capture the finished sum on the last accumulate edge and hold it through the next run
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      r_product <= 16'd0;
    end else if (r_state == CYC3) begin
      r_product <= w_accNext;
    end
  end

  assign bus.product8x8_out = r_product;
`else
  assign bus.product8x8_out = r_acc;
`endif

  assign bus.done_flag = r_done;
  assign bus.seg_state = r_state;

endmodule

// File: tb/tb_mult8x8_seq.sv
// tb_mult8x8_seq: directed, table-driven bench for mult8x8_seq.
// Inputs are driven 1 ns after a rising edge and outputs are sampled there too,
// well away from the next active edge.
`timescale 1ns/1ps
module tb_mult8x8_seq;

  logic clk;
  logic reset_a;
  int   assertCount;
  int   failCount;

  mult8x8_seq_if bus ();

  mult8x8_seq dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] expected;
  } vector_t;

  vector_t vectors [8];

  // Compare one observed value against its expected value and tally the result
  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive the request side of the interface
  task automatic applyStimulus(input logic startLevel, input logic [7:0] a, input logic [7:0] b);
    bus.start = startLevel;
    bus.dataa = a;
    bus.datab = b;
  endtask

  // Advance to just after the next rising edge
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle, wait (bounded) for done, check latency and product
  task automatic runMultiply(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] expected);
    int lat;
    applyStimulus(1'b1, a, b);
    stepCycle();
    applyStimulus(1'b0, 8'h00, 8'h00);
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      stepCycle();
      if (bus.done_flag === 1'b1) begin
        lat = c;
        break;
      end
    end
    checkOutput({name, " latency"}, 16'(lat), 16'd4);
    checkOutput({name, " product"}, bus.product8x8_out, expected);
    checkOutput({name, " seg"}, {13'd0, bus.seg_state}, 16'd4);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;

    vectors[0] = '{8'hFF, 8'hFF, 16'hFE01};
    vectors[1] = '{8'h00, 8'hA7, 16'h0000};
    vectors[2] = '{8'h12, 8'h34, 16'h03A8};
    vectors[3] = '{8'hA5, 8'h5A, 16'h3A02};
    vectors[4] = '{8'h01, 8'h01, 16'h0001};
    vectors[5] = '{8'h80, 8'h02, 16'h0100};
    vectors[6] = '{8'hFF, 8'h01, 16'h00FF};
    vectors[7] = '{8'h10, 8'h10, 16'h0100};

    // Reset state, with start asserted alongside reset
    reset_a = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00);
    #2;
    checkOutput("reset product", bus.product8x8_out, 16'h0000);
    checkOutput("reset done", {15'd0, bus.done_flag}, 16'd0);
    checkOutput("reset seg", {13'd0, bus.seg_state}, 16'd5);
    stepCycle();
    applyStimulus(1'b1, 8'h12, 8'h34);
    stepCycle();
    checkOutput("start under reset seg", {13'd0, bus.seg_state}, 16'd5);
    applyStimulus(1'b0, 8'h00, 8'h00);
    reset_a = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("idle holds seg", {13'd0, bus.seg_state}, 16'd5);
    checkOutput("idle holds done", {15'd0, bus.done_flag}, 16'd0);

    // seg_state walk for 0xFF * 0xFF: 5 then 0,1,2,3,4
    applyStimulus(1'b1, 8'hFF, 8'hFF);
    for (int s = 0; s <= 4; s++) begin
      stepCycle();
      applyStimulus(1'b0, 8'h00, 8'h00);
      checkOutput($sformatf("ff seq seg %0d", s), {13'd0, bus.seg_state}, 16'(s));
      checkOutput($sformatf("ff seq done %0d", s), {15'd0, bus.done_flag}, (s == 4) ? 16'd1 : 16'd0);
    end
    checkOutput("ff seq product", bus.product8x8_out, 16'hFE01);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      runMultiply($sformatf("vec%0d", i), vectors[i].a, vectors[i].b, vectors[i].expected);
    end

`ifndef MULT_HOLD_EN
    // Running partial sums for 0x12*0x34: 2*4, +(1*4)<<4, +(2*3)<<4, +(1*3)<<8
    applyStimulus(1'b1, 8'h12, 8'h34);
    stepCycle();
    applyStimulus(1'b0, 8'h00, 8'h00);
    checkOutput("acc at CYC0", bus.product8x8_out, 16'h0000);
    stepCycle();
    checkOutput("acc after CYC0", bus.product8x8_out, 16'h0008);
    stepCycle();
    checkOutput("acc after CYC1", bus.product8x8_out, 16'h0048);
    stepCycle();
    checkOutput("acc after CYC2", bus.product8x8_out, 16'h00A8);
    stepCycle();
    checkOutput("acc after CYC3", bus.product8x8_out, 16'h03A8);
    checkOutput("acc done", {15'd0, bus.done_flag}, 16'd1);
`else
    // Held output keeps the old result through a new run
    runMultiply("hold first", 8'h12, 8'h34, 16'h03A8);
    applyStimulus(1'b1, 8'h02, 8'h03);
    for (int s = 0; s <= 3; s++) begin
      stepCycle();
      applyStimulus(1'b0, 8'h00, 8'h00);
      checkOutput($sformatf("hold CYC%0d product", s), bus.product8x8_out, 16'h03A8);
    end
    stepCycle();
    checkOutput("hold done product", bus.product8x8_out, 16'h0006);
    checkOutput("hold done flag", {15'd0, bus.done_flag}, 16'd1);
`endif

    // start held high: mid-run operand changes are ignored, DONE lasts one cycle
    applyStimulus(1'b1, 8'h12, 8'h34);
    stepCycle();
    applyStimulus(1'b1, 8'hFF, 8'hFF);
    for (int s = 1; s <= 3; s++) stepCycle();
    checkOutput("held start seg CYC3", {13'd0, bus.seg_state}, 16'd3);
    stepCycle();
    checkOutput("held start done", {15'd0, bus.done_flag}, 16'd1);
    checkOutput("held start product", bus.product8x8_out, 16'h03A8);
    stepCycle();
    checkOutput("restart done falls", {15'd0, bus.done_flag}, 16'd0);
    checkOutput("restart seg", {13'd0, bus.seg_state}, 16'd0);
    applyStimulus(1'b0, 8'h00, 8'h00);
    for (int s = 1; s <= 4; s++) stepCycle();
    checkOutput("restart done", {15'd0, bus.done_flag}, 16'd1);
    checkOutput("restart product", bus.product8x8_out, 16'hFE01);

    // Asynchronous reset during CYC2 clears everything without a clock edge
    applyStimulus(1'b1, 8'hFF, 8'hFF);
    stepCycle();
    applyStimulus(1'b0, 8'h00, 8'h00);
    stepCycle();
    stepCycle();
    checkOutput("pre-reset seg", {13'd0, bus.seg_state}, 16'd2);
    reset_a = 1'b1;
    #1;
    checkOutput("async reset product", bus.product8x8_out, 16'h0000);
    checkOutput("async reset done", {15'd0, bus.done_flag}, 16'd0);
    checkOutput("async reset seg", {13'd0, bus.seg_state}, 16'd5);
    #1;
    reset_a = 1'b0;
    stepCycle();
    checkOutput("post-reset idle seg", {13'd0, bus.seg_state}, 16'd5);
    runMultiply("post reset", 8'h0F, 8'h11, 16'h00FF);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
